// File: rtl/avmm_pio_master_pkg.sv
// Shared types and limits for the Avalon-MM PIO master.
package avmm_pio_master_pkg;

    localparam int unsigned READ_LATENCY_MAX = 7;
    localparam int unsigned WAIT_CNT_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ADDR,
        READ_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/avmm_pio_master_poll_timer.sv
// Idle-cycle poll counter; o_due is raised once POLL_PERIOD-1 idle cycles have elapsed
// and holds until the poll is actually issued.
module avmm_pio_master_poll_timer
    import avmm_pio_master_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_idle,
    input  logic i_issue,
    output logic o_due
);

    localparam int unsigned    CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(POLL_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at LAST so a poll deferred by a command is still due on the next idle cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_issue) begin
            r_cnt <= '0;
        end else if (i_idle && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_due = (r_cnt == LAST);

endmodule

// File: rtl/avmm_pio_master.sv
// Avalon-MM PIO master: one command at a time, fixed-latency reads, one-cycle response pulse.
// Define AVMM_PIO_MASTER_POLL_EN to auto-poll address 0 into poll_data while idle.
//   state     | meaning
//   IDLE      | ready for a command (or issuing an auto-poll)
//   WRITE     | write strobe on the bus
//   READ_ADDR | read address presented, wait counter loaded
//   READ_WAIT | counting down slave latency, capture at terminal count
//   RESP      | rsp_valid pulse
module avmm_pio_master
    import avmm_pio_master_pkg::*;
#(
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_PERIOD  = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] poll_data,
    output logic              poll_change
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(READ_LATENCY - 1);

    if ((READ_LATENCY < 1) || (READ_LATENCY > READ_LATENCY_MAX) || (POLL_PERIOD < 1)) begin : g_bad_param
        $error("avmm_pio_master: READ_LATENCY must be 1..7 and POLL_PERIOD at least 1");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_is_poll;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_poll_issue;
    logic                  w_idle;

    assign w_idle = (r_state == IDLE);

`ifdef AVMM_PIO_MASTER_POLL_EN
    logic              w_poll_due;
    logic [DATA_W-1:0] r_poll_data;
    logic              r_poll_change;

    avmm_pio_master_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_poll_timer (
        .clk     (clk),
        .reset   (reset),
        .i_idle  (w_idle),
        .i_issue (w_poll_issue),
        .o_due   (w_poll_due)
    );

    // A pending command always beats a due poll.
    assign w_poll_issue = w_idle && w_poll_due && !cmd_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_poll_data   <= '0;
            r_poll_change <= 1'b0;
        end else begin
            r_poll_change <= 1'b0;
            if (w_capture && r_is_poll) begin
                r_poll_data   <= readdata;
                r_poll_change <= (readdata != r_poll_data);
            end
        end
    end

    assign poll_data   = r_poll_data;
    assign poll_change = r_poll_change;
`else
    assign w_poll_issue = 1'b0;
    assign poll_data    = '0;
    assign poll_change  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        rsp_valid   = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready = !w_poll_issue;
                w_accept  = cmd_valid && !w_poll_issue;
                if (w_poll_issue) begin
                    w_state_nxt = READ_ADDR;
                end else if (cmd_valid) begin
                    w_state_nxt = cmd_write ? WRITE : READ_ADDR;
                end
            end
            WRITE: begin
                chipselect  = 1'b1;
                write_n     = 1'b0;
                w_state_nxt = RESP;
            end
            READ_ADDR: begin
                chipselect  = 1'b1;
                w_state_nxt = READ_WAIT;
            end
            READ_WAIT: begin
                chipselect = 1'b1;
                if (r_wait_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = r_is_poll ? IDLE : RESP;
                end
            end
            RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
            r_is_poll  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_is_poll <= 1'b0;
            end else if (w_poll_issue) begin
                r_addr    <= '0;
                r_is_poll <= 1'b1;
            end

            if (r_state == READ_ADDR) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == READ_WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end

            // Response data only moves on a real command response; polls leave it alone.
            if (r_state == WRITE) begin
                r_rdata <= '0;
            end else if (w_capture && !r_is_poll) begin
                r_rdata <= readdata;
            end
        end
    end

    assign address   = r_addr;
    assign writedata = r_wdata;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_avmm_pio_master.sv
// Directed bench: two masters (read latency 1 and 3) against a registered-latency PIO slave model.
module tb_avmm_pio_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid_a = 1'b0;
    logic        cmd_valid_b = 1'b0;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_addr = 2'd0;
    logic [31:0] cmd_wdata = 32'd0;

    logic        cmd_ready_a, rsp_valid_a, chipselect_a, write_n_a, poll_change_a;
    logic [31:0] rsp_rdata_a, writedata_a, readdata_a, poll_data_a;
    logic [1:0]  address_a;
    logic        cmd_ready_b, rsp_valid_b, chipselect_b, write_n_b, poll_change_b;
    logic [31:0] rsp_rdata_b, writedata_b, readdata_b, poll_data_b;
    logic [1:0]  address_b;

    logic [31:0] in_regs [4];
    logic [31:0] pipe_a  [7];
    logic [31:0] pipe_b  [7];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rsp_cnt_a = 0;
    int rsp_cnt_b = 0;
    int chg_cnt_a = 0;
    int cs_cnt_a  = 0;

    always #5 clk = ~clk;

    avmm_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(1), .POLL_PERIOD(8)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .address(address_a),
        .chipselect(chipselect_a), .write_n(write_n_a), .writedata(writedata_a),
        .readdata(readdata_a), .poll_data(poll_data_a), .poll_change(poll_change_a)
    );

    avmm_pio_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(3), .POLL_PERIOD(8)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .address(address_b),
        .chipselect(chipselect_b), .write_n(write_n_b), .writedata(writedata_b),
        .readdata(readdata_b), .poll_data(poll_data_b), .poll_change(poll_change_b)
    );

    // Slave: register file read through a pipeline, data valid READ_LATENCY cycles after address.
    always @(posedge clk) begin
        pipe_a[0] <= in_regs[address_a];
        pipe_b[0] <= in_regs[address_b];
        for (int i = 1; i < 7; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign readdata_a = pipe_a[0];
    assign readdata_b = pipe_b[2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid_a === 1'b1)   rsp_cnt_a <= rsp_cnt_a + 1;
        if (rsp_valid_b === 1'b1)   rsp_cnt_b <= rsp_cnt_b + 1;
        if (poll_change_a === 1'b1) chg_cnt_a <= chg_cnt_a + 1;
        if (chipselect_a === 1'b1)  cs_cnt_a  <= cs_cnt_a + 1;
    end

    task automatic issue_cmd(input bit use_b, input bit wr, input logic [1:0] a,
                             input logic [31:0] d, input string name, output int waited);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        if (use_b) cmd_valid_b = 1'b1;
        else       cmd_valid_a = 1'b1;
        waited = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if ((use_b ? cmd_ready_b : cmd_ready_a) === 1'b1) begin
                waited = i;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (waited < 0) $display("FAIL %s_accept: cmd_ready stayed low, required acceptance within 40 cycles", name);
        else n_pass++;
    endtask

    task automatic drop_cmd();
        cmd_valid_a = 1'b0;
        cmd_valid_b = 1'b0;
        cmd_addr    = 2'b11;
        cmd_wdata   = 32'hDEAD_BEEF;
        cmd_write   = ~cmd_write;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({chipselect_a, write_n_a, address_a, writedata_a, rsp_valid_a, rsp_rdata_a, poll_data_a, poll_change_a}
            !== {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0})
            $display("FAIL reset_a: cs=%b wn=%b addr=%h wd=%h rv=%b rd=%h pd=%h pc=%b, required 0 1 0 0 0 0 0 0",
                     chipselect_a, write_n_a, address_a, writedata_a, rsp_valid_a, rsp_rdata_a, poll_data_a, poll_change_a);
        else n_pass++;
        n_checks++;
        if ({chipselect_b, write_n_b, address_b, writedata_b, rsp_valid_b, rsp_rdata_b, poll_data_b, poll_change_b}
            !== {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0})
            $display("FAIL reset_b: cs=%b wn=%b addr=%h rv=%b rd=%h, required 0 1 0 0 0",
                     chipselect_b, write_n_b, address_b, rsp_valid_b, rsp_rdata_b);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({cmd_ready_a, cmd_ready_b} !== 2'b11)
            $display("FAIL reset_ready: got %b, required 11", {cmd_ready_a, cmd_ready_b});
        else n_pass++;
    endtask

    task automatic test_read_lat1();
        int w;
        in_regs[0] = 32'h1234_5678;
        @(negedge clk);
        issue_cmd(1'b0, 1'b0, 2'd0, 32'h0, "read1", w);
        @(negedge clk); drop_cmd(); #1;
        n_checks++;
        if ({chipselect_a, write_n_a, address_a, cmd_ready_a} !== {1'b1, 1'b1, 2'd0, 1'b0})
            $display("FAIL read1_addr: cs/wn/addr/rdy=%b%b%h%b, required 1 1 0 0", chipselect_a, write_n_a, address_a, cmd_ready_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({chipselect_a, rsp_valid_a} !== 2'b10)
            $display("FAIL read1_wait: cs/rv=%b%b, required 10", chipselect_a, rsp_valid_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({rsp_valid_a, rsp_rdata_a, chipselect_a} !== {1'b1, 32'h1234_5678, 1'b0})
            $display("FAIL read1_resp: rv=%b rd=%h cs=%b, required 1 12345678 0", rsp_valid_a, rsp_rdata_a, chipselect_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({rsp_valid_a, rsp_rdata_a} !== {1'b0, 32'h1234_5678})
            $display("FAIL read1_hold: rv=%b rd=%h, required 0 12345678", rsp_valid_a, rsp_rdata_a);
        else n_pass++;
    endtask

    task automatic test_write();
        int w;
        @(negedge clk);
        issue_cmd(1'b0, 1'b1, 2'd0, 32'hA5A5_0001, "write", w);
        @(negedge clk); drop_cmd(); #1;
        n_checks++;
        if ({chipselect_a, write_n_a, address_a, writedata_a} !== {1'b1, 1'b0, 2'd0, 32'hA5A5_0001})
            $display("FAIL write_bus: cs=%b wn=%b addr=%h wd=%h, required 1 0 0 a5a50001",
                     chipselect_a, write_n_a, address_a, writedata_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({rsp_valid_a, rsp_rdata_a, chipselect_a} !== {1'b1, 32'd0, 1'b0})
            $display("FAIL write_resp: rv=%b rd=%h cs=%b, required 1 0 0", rsp_valid_a, rsp_rdata_a, chipselect_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({rsp_valid_a, chipselect_a, write_n_a} !== 3'b001)
            $display("FAIL write_done: rv/cs/wn=%b%b%b, required 001", rsp_valid_a, chipselect_a, write_n_a);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w;
        int base;
        in_regs[2] = 32'h2222_BEEF;
        @(negedge clk);
        base = rsp_cnt_a;
        issue_cmd(1'b0, 1'b1, 2'd1, 32'h0000_0011, "b2b_first", w);
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 2'd2; cmd_wdata = 32'h0;
        #1;
        n_checks++;
        if ({cmd_ready_a, address_a, writedata_a} !== {1'b0, 2'd1, 32'h11})
            $display("FAIL b2b_t1: rdy=%b addr=%h wd=%h, required 0 1 00000011", cmd_ready_a, address_a, writedata_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({cmd_ready_a, rsp_valid_a} !== 2'b01)
            $display("FAIL b2b_t2: rdy/rv=%b%b, required 01", cmd_ready_a, rsp_valid_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (cmd_ready_a !== 1'b1)
            $display("FAIL b2b_t3: rdy=%b, required 1", cmd_ready_a);
        else n_pass++;
        @(negedge clk); drop_cmd(); #1;
        n_checks++;
        if ({chipselect_a, write_n_a, address_a} !== {1'b1, 1'b1, 2'd2})
            $display("FAIL b2b_read_addr: cs=%b wn=%b addr=%h, required 1 1 2", chipselect_a, write_n_a, address_a);
        else n_pass++;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid_a, rsp_rdata_a} !== {1'b1, 32'h2222_BEEF})
            $display("FAIL b2b_read_resp: rv=%b rd=%h, required 1 2222beef", rsp_valid_a, rsp_rdata_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (rsp_cnt_a - base !== 2)
            $display("FAIL b2b_rsp_count: got %0d, required 2", rsp_cnt_a - base);
        else n_pass++;
    endtask

    task automatic test_read_lat3();
        int w;
        in_regs[1] = 32'hCAFE_0003;
        @(negedge clk);
        issue_cmd(1'b1, 1'b0, 2'd1, 32'h0, "read3", w);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) drop_cmd();
            #1;
            n_checks++;
            if ({chipselect_b, write_n_b, address_b, rsp_valid_b} !== {1'b1, 1'b1, 2'd1, 1'b0})
                $display("FAIL read3_hold_t%0d: cs=%b wn=%b addr=%h rv=%b, required 1 1 1 0",
                         k, chipselect_b, write_n_b, address_b, rsp_valid_b);
            else n_pass++;
        end
        @(negedge clk); #1;
        n_checks++;
        if ({rsp_valid_b, rsp_rdata_b, chipselect_b} !== {1'b1, 32'hCAFE_0003, 1'b0})
            $display("FAIL read3_resp: rv=%b rd=%h cs=%b, required 1 cafe0003 0", rsp_valid_b, rsp_rdata_b, chipselect_b);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int w;
        int base;
        @(negedge clk);
        base = rsp_cnt_b;
        issue_cmd(1'b1, 1'b0, 2'd1, 32'h0, "rstmid", w);
        @(negedge clk); drop_cmd();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({chipselect_b, write_n_b, rsp_valid_b, address_b} !== {1'b0, 1'b1, 1'b0, 2'd0})
            $display("FAIL rstmid_abort: cs=%b wn=%b rv=%b addr=%h, required 0 1 0 0",
                     chipselect_b, write_n_b, rsp_valid_b, address_b);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (cmd_ready_b !== 1'b1)
            $display("FAIL rstmid_ready: rdy=%b, required 1", cmd_ready_b);
        else n_pass++;
        repeat (6) @(negedge clk);
        n_checks++;
        if (rsp_cnt_b != base)
            $display("FAIL rstmid_no_rsp: rsp pulses %0d, required 0", rsp_cnt_b - base);
        else n_pass++;
    endtask

`ifdef AVMM_PIO_MASTER_POLL_EN
    task automatic test_poll_change();
        int rsp0, chg0, first, second, rises;
        logic prev;
        in_regs[0] = 32'h0;
        first = -1; second = -1; rises = 0;
        @(negedge clk); #1;
        prev = chipselect_a;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (!prev && chipselect_a) begin
                rises++;
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            prev = chipselect_a;
        end
        n_checks++;
        if (rises < 2 || (second - first) != 10)
            $display("FAIL poll_period: rises=%0d spacing=%0d, required >=2 rises spaced 10 cycles", rises, second - first);
        else n_pass++;
        rsp0 = rsp_cnt_a; chg0 = chg_cnt_a;
        in_regs[0] = 32'h3;
        repeat (30) @(negedge clk);
        #1;
        n_checks++;
        if (poll_data_a !== 32'h3)
            $display("FAIL poll_data: got %h, required 00000003", poll_data_a);
        else n_pass++;
        n_checks++;
        if (chg_cnt_a - chg0 != 1)
            $display("FAIL poll_change_count: got %0d, required 1", chg_cnt_a - chg0);
        else n_pass++;
        n_checks++;
        if (rsp_cnt_a != rsp0)
            $display("FAIL poll_no_rsp: got %0d rsp pulses, required 0", rsp_cnt_a - rsp0);
        else n_pass++;
    endtask

    task automatic test_poll_defer();
        int w;
        bit found;
        logic prev;
        found = 1'b0;
        @(negedge clk); #1;
        prev = chipselect_a;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); #1;
            if (prev && !chipselect_a) found = 1'b1;
            prev = chipselect_a;
        end
        n_checks++;
        if (!found) $display("FAIL defer_sync: poll end not observed within 40 cycles, required one");
        else n_pass++;
        repeat (7) @(negedge clk);
        issue_cmd(1'b0, 1'b1, 2'd2, 32'h0000_0042, "defer", w);
        n_checks++;
        if (w != 0) $display("FAIL defer_ready: waited %0d cycles, required 0", w);
        else n_pass++;
        @(negedge clk); drop_cmd(); #1;
        n_checks++;
        if ({chipselect_a, write_n_a, address_a} !== {1'b1, 1'b0, 2'd2})
            $display("FAIL defer_write: cs=%b wn=%b addr=%h, required 1 0 2", chipselect_a, write_n_a, address_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (rsp_valid_a !== 1'b1) $display("FAIL defer_resp: rv=%b, required 1", rsp_valid_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({chipselect_a, cmd_ready_a} !== 2'b00)
            $display("FAIL defer_poll_issue: cs=%b rdy=%b, required 0 0", chipselect_a, cmd_ready_a);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({chipselect_a, write_n_a, address_a} !== {1'b1, 1'b1, 2'd0})
            $display("FAIL defer_poll_read: cs=%b wn=%b addr=%h, required 1 1 0", chipselect_a, write_n_a, address_a);
        else n_pass++;
    endtask
`else
    task automatic test_no_poll();
        int cs0, chg0;
        in_regs[0] = 32'h3;
        @(negedge clk);
        cs0 = cs_cnt_a; chg0 = chg_cnt_a;
        repeat (30) @(negedge clk);
        #1;
        n_checks++;
        if (cs_cnt_a != cs0) $display("FAIL nopoll_bus: %0d chipselect cycles, required 0", cs_cnt_a - cs0);
        else n_pass++;
        n_checks++;
        if ({poll_data_a, poll_data_b} !== 64'd0)
            $display("FAIL nopoll_data: got %h %h, required 0 0", poll_data_a, poll_data_b);
        else n_pass++;
        n_checks++;
        if (chg_cnt_a != chg0) $display("FAIL nopoll_change: %0d pulses, required 0", chg_cnt_a - chg0);
        else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) in_regs[i] = 32'h0;
        test_reset();
        test_read_lat1();
        test_write();
        test_back_to_back();
        test_read_lat3();
        test_reset_mid();
`ifdef AVMM_PIO_MASTER_POLL_EN
        test_poll_change();
        test_poll_defer();
`else
        test_no_poll();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
